// File: rtl/condicionador_botoes.sv
`default_nettype none
// ============================================================================
// Module      : condicionador_botoes
// Description : Two-flop synchroniser, debounce FSM and one-hot validation for
//               four push-buttons feeding the game circuit. Optional macro
//               PULSO_NA_SOLTURA_EN moves the jogada_valida pulse to release.
// Revision    : 1.0 - initial release
// ============================================================================
module condicionador_botoes #(
  parameter int CLOCK_FREQ  = 5000,
  parameter int DEBOUNCE_MS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_in,
  output logic [3:0] botoes_out,
  output logic       jogada_valida,
  output logic       multipla,
  output logic [1:0] db_estado
);

  localparam int c_N_RAW = (CLOCK_FREQ * DEBOUNCE_MS) / 1000;
  localparam int c_N     = (c_N_RAW < 1) ? 1 : c_N_RAW;
  localparam int c_CW    = $clog2(c_N) + 1;
  localparam logic [c_CW-1:0] c_N_MAX = c_CW'(c_N - 1);
  localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    ESTABILIZANDO = 2'd1,
    PRESSIONADO   = 2'd2,
    SOLTANDO      = 2'd3
  } estado_t;

  estado_t         r_estado;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_amostra;
  logic [c_CW-1:0] r_cnt;
  logic [3:0]      r_botoes;
  logic            r_jogada;
  logic            r_multipla;

  logic            w_one_hot;
  logic            w_sync_zero;
  logic            w_cnt_fim;

  assign w_one_hot   = (r_amostra != 4'd0) && ((r_amostra & (r_amostra - 4'd1)) == 4'd0);
  assign w_sync_zero = (r_sync2 == 4'd0);
  assign w_cnt_fim   = (r_cnt == c_N_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_sync1    <= 4'd0;
      r_sync2    <= 4'd0;
      r_amostra  <= 4'd0;
      r_cnt      <= '0;
      r_botoes   <= 4'd0;
      r_jogada   <= 1'b0;
      r_multipla <= 1'b0;
    end else begin
      r_sync1    <= botoes_in;
      r_sync2    <= r_sync1;
      r_jogada   <= 1'b0;
      r_multipla <= 1'b0;

      case (r_estado)
        OCIOSO: begin
`ifdef PULSO_NA_SOLTURA_EN
          // Code was held through the release pulse cycle; drop it now.
          r_botoes <= 4'd0;
`endif
          if (!w_sync_zero) begin
            r_estado  <= ESTABILIZANDO;
            r_amostra <= r_sync2;
            r_cnt     <= '0;
          end
        end

        ESTABILIZANDO: begin
          if (w_sync_zero) begin
            r_estado <= OCIOSO;
          end else if (r_sync2 != r_amostra) begin
            r_amostra <= r_sync2;
            r_cnt     <= '0;
          end else if (w_cnt_fim) begin
            r_estado <= PRESSIONADO;
            if (w_one_hot) begin
              r_botoes <= r_amostra;
`ifndef PULSO_NA_SOLTURA_EN
              r_jogada <= 1'b1;
`endif
            end else begin
              r_multipla <= 1'b1;
            end
          end else if (r_cnt < c_N_MAX) begin
            r_cnt <= r_cnt + c_ONE;
          end
        end

        PRESSIONADO: begin
          if (w_sync_zero) begin
            r_estado <= SOLTANDO;
            r_cnt    <= '0;
          end
        end

        SOLTANDO: begin
          if (!w_sync_zero) begin
            r_estado <= PRESSIONADO;
          end else if (w_cnt_fim) begin
            r_estado <= OCIOSO;
`ifdef PULSO_NA_SOLTURA_EN
            r_jogada <= (r_botoes != 4'd0);
`else
            r_botoes <= 4'd0;
`endif
          end else if (r_cnt < c_N_MAX) begin
            r_cnt <= r_cnt + c_ONE;
          end
        end

        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign botoes_out    = r_botoes;
  assign jogada_valida = r_jogada;
  assign multipla      = r_multipla;
  assign db_estado     = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_condicionador_botoes.sv
`default_nettype none
// Testbench for condicionador_botoes: directed button sequences, expected
// pulses queued with their cycle number and checked by a separate monitor.
module tb_condicionador_botoes;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] botoes_in = 4'd0;
  logic [3:0] botoes_out;
  logic       jogada_valida;
  logic       multipla;
  logic [1:0] db_estado;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit         mul;
    int         at;
    logic [3:0] code;
  } ev_t;
  ev_t q[$];

  condicionador_botoes #(
    .CLOCK_FREQ (5000),
    .DEBOUNCE_MS(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes_in    (botoes_in),
    .botoes_out   (botoes_out),
    .jogada_valida(jogada_valida),
    .multipla     (multipla),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input bit mul, input int at, input logic [3:0] code);
    ev_t e;
    e.mul = mul; e.at = at; e.code = code;
    q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clock) begin
    if (!reset && (jogada_valida || multipla)) begin
      ev_t e;
      if (jogada_valida && multipla) chk("both_pulses", 8'd1, 8'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {6'd0, multipla, jogada_valida}, 8'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {7'd0, multipla}, {7'd0, e.mul});
        chk("pulse_cycle", 8'(cyc), 8'(e.at));
        chk("pulse_code", {4'd0, botoes_out}, {4'd0, (e.mul ? 4'd0 : e.code)});
      end
    end
  end

  initial begin
    int t;
    // Reset with a button held
    reset = 1'b1; botoes_in = 4'b0010;
    tick(2);
    chk("rst_botoes_out", {4'd0, botoes_out}, 8'd0);
    chk("rst_jogada", {7'd0, jogada_valida}, 8'd0);
    chk("rst_multipla", {7'd0, multipla}, 8'd0);
    chk("rst_estado", {6'd0, db_estado}, 8'd0);
    reset = 1'b0;
`ifndef PULSO_NA_SOLTURA_EN
    push(1'b0, cyc + 13, 4'b0010);
`endif
    tick(20);
    chk("post_rst_code", {4'd0, botoes_out}, 8'h02);
    botoes_in = 4'd0; t = cyc;
`ifdef PULSO_NA_SOLTURA_EN
    push(1'b0, t + 13, 4'b0010);
`endif
    tick(20);
    chk("post_rst_release", {4'd0, botoes_out}, 8'd0);

    // Clean press of 4'b0100
    botoes_in = 4'b0100; t = cyc;
`ifndef PULSO_NA_SOLTURA_EN
    push(1'b0, t + 13, 4'b0100);
`endif
    tick(12);
    chk("clean_before_acc", {4'd0, botoes_out}, 8'd0);
    tick(1);
    chk("clean_accepted", {4'd0, botoes_out}, 8'h04);
    chk("clean_estado", {6'd0, db_estado}, 8'd2);
    tick(27);
    botoes_in = 4'd0; t = cyc;
`ifdef PULSO_NA_SOLTURA_EN
    push(1'b0, t + 13, 4'b0100);
`endif
    tick(12);
    chk("clean_rel_hold", {4'd0, botoes_out}, 8'h04);
    tick(1);
`ifdef PULSO_NA_SOLTURA_EN
    chk("clean_rel_pulse_code", {4'd0, botoes_out}, 8'h04);
    tick(1);
`endif
    chk("clean_rel_clear", {4'd0, botoes_out}, 8'd0);
    tick(5);

    // Glitch rejection
    botoes_in = 4'b0001;
    tick(5);
    chk("glitch_estab", {6'd0, db_estado}, 8'd1);
    botoes_in = 4'd0;
    tick(20);
    chk("glitch_code", {4'd0, botoes_out}, 8'd0);
    chk("glitch_estado", {6'd0, db_estado}, 8'd0);

    // Press bounce, then release bounce
    for (int i = 0; i < 4; i++) begin
      botoes_in = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      tick(3);
    end
    botoes_in = 4'b1000; t = cyc;
`ifndef PULSO_NA_SOLTURA_EN
    push(1'b0, t + 13, 4'b1000);
`endif
    tick(30);
    chk("bounce_code", {4'd0, botoes_out}, 8'h08);
    botoes_in = 4'd0;
    tick(3);
    botoes_in = 4'b1000;
    tick(3);
    botoes_in = 4'd0; t = cyc;
`ifdef PULSO_NA_SOLTURA_EN
    push(1'b0, t + 13, 4'b1000);
`endif
    tick(12);
    chk("bounce_rel_hold", {4'd0, botoes_out}, 8'h08);
    tick(8);
    chk("bounce_rel_clear", {4'd0, botoes_out}, 8'd0);

    // Two buttons at once
    botoes_in = 4'b0011; t = cyc;
    push(1'b1, t + 13, 4'b0000);
    tick(20);
    chk("multi_code", {4'd0, botoes_out}, 8'd0);
    chk("multi_estado", {6'd0, db_estado}, 8'd2);
    botoes_in = 4'd0;
    tick(20);
    chk("multi_idle", {6'd0, db_estado}, 8'd0);

    // Reset while pressed
    botoes_in = 4'b0001; t = cyc;
`ifndef PULSO_NA_SOLTURA_EN
    push(1'b0, t + 13, 4'b0001);
`endif
    tick(20);
    chk("midrst_code_before", {4'd0, botoes_out}, 8'h01);
    reset = 1'b1; botoes_in = 4'd0;
    tick(1);
    chk("midrst_code_after", {4'd0, botoes_out}, 8'd0);
    chk("midrst_estado", {6'd0, db_estado}, 8'd0);
    tick(1);
    reset = 1'b0;
    tick(20);
    chk("midrst_idle", {4'd0, botoes_out}, 8'd0);

    chk("pending_events", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
